// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - N-sprite 1-bit compositor with shadowed attributes and per-frame collision flags
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SP_SIZE     = 16,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int SP_AW       = 8,
    parameter int TRANSPARENT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_end,
    input  logic                         pix_valid,
    input  logic [X_W-1:0]               pix_x,
    input  logic [Y_W-1:0]               pix_y,
    input  logic [NUM_SPRITES-1:0]       sp_en_in,
    input  logic [NUM_SPRITES*X_W-1:0]   sp_x_in,
    input  logic [NUM_SPRITES*Y_W-1:0]   sp_y_in,
    input  logic [NUM_SPRITES*SP_AW-1:0] sp_base_in,
    output logic [NUM_SPRITES*SP_AW-1:0] sp_mem_addr,
    input  logic [NUM_SPRITES-1:0]       sp_mem_data,
    input  logic                         bkg_data,
    output logic                         out_valid,
    output logic                         out_pix,
    output logic [3:0]                   out_src,
    output logic [NUM_SPRITES-1:0]       coll_sp,
    output logic [NUM_SPRITES-1:0]       coll_bkg
);

    logic [NUM_SPRITES-1:0]       sh_en;
    logic [NUM_SPRITES*X_W-1:0]   sh_x;
    logic [NUM_SPRITES*Y_W-1:0]   sh_y;
    logic [NUM_SPRITES*SP_AW-1:0] sh_base;

    logic                   v1, v2;
    logic [NUM_SPRITES-1:0] hit1, hit2;
    logic [NUM_SPRITES-1:0] hit_c;
    logic [SP_AW-1:0]       addr_c [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] opq;
    logic [NUM_SPRITES-1:0] contrib_sp, contrib_bkg;
    logic [NUM_SPRITES-1:0] acc_sp, acc_bkg;
    logic [3:0]             win_src;
    logic                   win_pix;

    // Bounds are compared one bit wider so a box near the right/bottom edge never wraps to 0.
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sp
        logic [X_W:0]     sx, px;
        logic [Y_W:0]     sy, py;
        logic [X_W-1:0]   dx;
        logic [Y_W-1:0]   dy;
        logic [NUM_SPRITES-1:0] others;

        assign sx = {1'b0, sh_x[g*X_W +: X_W]};
        assign px = {1'b0, pix_x};
        assign sy = {1'b0, sh_y[g*Y_W +: Y_W]};
        assign py = {1'b0, pix_y};
        assign hit_c[g] = sh_en[g] && (px >= sx) && (px < sx + (X_W+1)'(SP_SIZE))
                                   && (py >= sy) && (py < sy + (Y_W+1)'(SP_SIZE));
        assign dx = pix_x - sh_x[g*X_W +: X_W];
        assign dy = pix_y - sh_y[g*Y_W +: Y_W];
        assign addr_c[g] = sh_base[g*SP_AW +: SP_AW] + SP_AW'(dx)
                         + SP_AW'(dy) * SP_AW'(SP_SIZE);

        assign others         = opq & ~(NUM_SPRITES'(1) << g);
        assign contrib_sp[g]  = opq[g] && (others != '0);
        assign contrib_bkg[g] = opq[g] && bkg_data;
    end

    assign opq = hit2 & {NUM_SPRITES{v2}}
               & ((TRANSPARENT != 0) ? sp_mem_data : {NUM_SPRITES{1'b1}});

    // Walk from the top index down so the lowest-index opaque sprite is assigned last and wins.
    always_comb begin
        win_src = 4'd0;
        win_pix = bkg_data;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opq[i]) begin
                win_src = 4'(i + 1);
                win_pix = sp_mem_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_en       <= '0;
            sh_x        <= '0;
            sh_y        <= '0;
            sh_base     <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            hit1        <= '0;
            hit2        <= '0;
            sp_mem_addr <= '0;
            out_valid   <= 1'b0;
            out_pix     <= 1'b0;
            out_src     <= 4'd0;
            coll_sp     <= '0;
            coll_bkg    <= '0;
            acc_sp      <= '0;
            acc_bkg     <= '0;
        end else begin
            if (frame_end) begin
                sh_en   <= sp_en_in;
                sh_x    <= sp_x_in;
                sh_y    <= sp_y_in;
                sh_base <= sp_base_in;
            end

            v1   <= pix_valid;
            hit1 <= hit_c & {NUM_SPRITES{pix_valid}};
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (pix_valid && hit_c[i])
                    sp_mem_addr[i*SP_AW +: SP_AW] <= addr_c[i];
            end

            v2   <= v1;
            hit2 <= hit1;

            out_valid <= v2;
            if (v2) begin
                out_pix <= win_pix;
                out_src <= win_src;
            end

            // The pixel finishing on the frame_end cycle is credited to the closing frame.
            if (frame_end) begin
                coll_sp  <= acc_sp | contrib_sp;
                coll_bkg <= acc_bkg | contrib_bkg;
                acc_sp   <= '0;
                acc_bkg  <= '0;
            end else begin
                acc_sp  <= acc_sp | contrib_sp;
                acc_bkg <= acc_bkg | contrib_bkg;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - scoreboard bench for sprite_compositor
module tb_sprite_compositor;
    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int AW = 8;
    localparam int SZ = 16;

    logic            clk = 1'b0;
    logic            reset, frame_end, pix_valid;
    logic [XW-1:0]   pix_x;
    logic [YW-1:0]   pix_y;
    logic [N-1:0]    sp_en_in;
    logic [N*XW-1:0] sp_x_in;
    logic [N*YW-1:0] sp_y_in;
    logic [N*AW-1:0] sp_base_in;
    logic [N*AW-1:0] sp_mem_addr;
    logic [N-1:0]    sp_mem_data;
    logic            bkg_data;
    logic            out_valid, out_pix;
    logic [3:0]      out_src;
    logic [N-1:0]    coll_sp, coll_bkg;

    sprite_compositor #(.NUM_SPRITES(N), .SP_SIZE(SZ), .X_W(XW), .Y_W(YW),
                        .SP_AW(AW), .TRANSPARENT(1)) dut (
        .clk(clk), .reset(reset), .frame_end(frame_end), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .sp_en_in(sp_en_in), .sp_x_in(sp_x_in),
        .sp_y_in(sp_y_in), .sp_base_in(sp_base_in), .sp_mem_addr(sp_mem_addr),
        .sp_mem_data(sp_mem_data), .bkg_data(bkg_data), .out_valid(out_valid),
        .out_pix(out_pix), .out_src(out_src), .coll_sp(coll_sp), .coll_bkg(coll_bkg)
    );

    always #5 clk = ~clk;

    logic [255:0] gram [N];
    logic         bkg_req, bkg_d1;
    int           m_en [N], m_x [N], m_y [N], m_base [N];
    logic [N-1:0] m_acc_sp, m_acc_bkg;
    logic [4:0]   sb [$];
    logic [3:0]   last_src;
    int           errors = 0;
    int           checks = 0;

    // GRAM with one cycle of read latency; background is delayed to line up with it.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            sp_mem_data[i] <= gram[i][sp_mem_addr[i*AW +: AW]];
        bkg_d1   <= bkg_req;
        bkg_data <= bkg_d1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                chk("out_src", 32'(out_src), 32'(e[3:0]));
                chk("out_pix", 32'(out_pix), 32'(e[4]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sp(input int i, input int x, input int y, input int base);
        sp_x_in[i*XW +: XW]    = XW'(x);
        sp_y_in[i*YW +: YW]    = YW'(y);
        sp_base_in[i*AW +: AW] = AW'(base);
    endtask

    task automatic pixel(input int x, input int y, input logic bkg);
        logic [N-1:0] opq, oth;
        logic [3:0]   src;
        logic         pv;
        int           a;
        opq = '0;
        src = 4'd0;
        pv  = bkg;
        for (int i = 0; i < N; i++) begin
            if (m_en[i] != 0 && x >= m_x[i] && x < m_x[i] + SZ && y >= m_y[i] && y < m_y[i] + SZ) begin
                a = (m_base[i] + (x - m_x[i]) + (y - m_y[i]) * SZ) % 256;
                opq[i] = gram[i][a];
            end
        end
        for (int i = N - 1; i >= 0; i--)
            if (opq[i]) begin
                src = 4'(i + 1);
                pv  = 1'b1;
            end
        for (int i = 0; i < N; i++) begin
            oth = opq;
            oth[i] = 1'b0;
            if (opq[i] && oth != '0) m_acc_sp[i] = 1'b1;
            if (opq[i] && bkg) m_acc_bkg[i] = 1'b1;
        end
        sb.push_back({pv, src});
        last_src  = src;
        pix_x     = XW'(x);
        pix_y     = YW'(y);
        bkg_req   = bkg;
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic frame();
        idle(4);
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_en[i]   = int'(sp_en_in[i]);
            m_x[i]    = int'(sp_x_in[i*XW +: XW]);
            m_y[i]    = int'(sp_y_in[i*YW +: YW]);
            m_base[i] = int'(sp_base_in[i*AW +: AW]);
        end
        chk("coll_sp", 32'(coll_sp), 32'(m_acc_sp));
        chk("coll_bkg", 32'(coll_bkg), 32'(m_acc_bkg));
        m_acc_sp  = '0;
        m_acc_bkg = '0;
    endtask

    initial begin
        reset = 1'b1; frame_end = 1'b0; pix_valid = 1'b0; pix_x = '0; pix_y = '0;
        sp_en_in = '0; sp_x_in = '0; sp_y_in = '0; sp_base_in = '0;
        bkg_req = 1'b0; bkg_d1 = 1'b0; bkg_data = 1'b0; sp_mem_data = '0;
        m_acc_sp = '0; m_acc_bkg = '0; last_src = 4'd0;
        for (int i = 0; i < N; i++) begin
            gram[i] = '1;
            m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_base[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_pix", 32'(out_pix), 32'd0);
        chk("rst_coll_sp", 32'(coll_sp), 32'd0);
        chk("rst_coll_bkg", 32'(coll_bkg), 32'd0);
        chk("rst_addr", sp_mem_addr, 32'd0);

        // Sprites stay disabled until the first frame_end.
        set_sp(0, 10, 20, 0);
        sp_en_in = 4'b0001;
        pixel(10, 20, 0);
        frame();
        pixel(10, 20, 0);
        chk("addr0_origin", 32'(sp_mem_addr[7:0]), 32'h00);
        pixel(11, 21, 0);
        chk("addr0_offset", 32'(sp_mem_addr[7:0]), 32'h11);
        pixel(9, 20, 1);

        set_sp(1, 4, 4, 8'h40);
        sp_en_in = 4'b0011;
        frame();
        pixel(7, 6, 0);
        chk("addr1_math", 32'(sp_mem_addr[15:8]), 32'h63);

        set_sp(0, 50, 50, 0);
        set_sp(2, 50, 50, 0);
        sp_en_in = 4'b0101;
        gram[0] = '0;
        frame();
        pixel(52, 53, 0);
        idle(4);
        gram[0] = '1;
        pixel(52, 53, 1);
        idle(5);
        chk("bubble_valid", 32'(out_valid), 32'd0);
        chk("bubble_hold_src", 32'(out_src), 32'(last_src));

        set_sp(0, 250, 0, 0);
        sp_en_in = 4'b0001;
        frame();
        pixel(3, 0, 1);
        pixel(255, 0, 0);
        pixel(250, 15, 0);
        pixel(250, 16, 0);
        pixel(249, 0, 0);

        set_sp(0, 100, 0, 0);
        pixel(251, 0, 0);
        frame();
        pixel(251, 0, 0);
        pixel(100, 0, 0);

        set_sp(0, 30, 30, 0);
        set_sp(1, 45, 45, 0);
        sp_en_in = 4'b0011;
        frame();
        pixel(45, 45, 1);
        pixel(31, 31, 0);
        frame();
        chk("coll_sp_pair", 32'(coll_sp), 32'h3);
        chk("coll_bkg_pair", 32'(coll_bkg), 32'h3);
        set_sp(1, 80, 80, 0);
        frame();
        pixel(30, 30, 1);
        frame();
        chk("coll_sp_apart", 32'(coll_sp), 32'h0);
        chk("coll_bkg_apart", 32'(coll_bkg), 32'h1);

        // Reset with a pixel in flight: nothing may come out afterwards.
        pix_x = 8'd30; pix_y = 7'd30; pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_en[i] = 0;
        m_acc_sp = '0;
        m_acc_bkg = '0;
        repeat (4) begin
            @(negedge clk);
            chk("flush_valid", 32'(out_valid), 32'd0);
        end
        chk("flush_coll_sp", 32'(coll_sp), 32'd0);
        @(posedge clk);
        #1;
        pixel(30, 30, 0);

        idle(6);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised N-sprite compositor for the 160x120 framebuffer path. It sits between the VGA timing generator (downscaled x/y) and the final color mux.
- Per pixel it generates sprite GRAM read addresses, merges the returned 1-bit sprite data over a 1-bit background by fixed priority, and outputs the composited bit plus a source tag.
- Sprite attributes are double-buffered on frame_end to prevent tearing. Per-frame sprite/sprite and sprite/background collision flags are reported to the CPU side.

Parameters:
NUM_SPRITES, 4, number of sprite channels (1..8)
SP_SIZE, 16, sprite edge length in pixels; square; power of 2
X_W, 8, width of x coordinates
Y_W, 7, width of y coordinates
SP_AW, 8, sprite GRAM address width per channel
TRANSPARENT, 1, 1: sprite pixel 0 is see-through; 0: sprite box is fully opaque

Ports:
clk  in  1  system clock; all logic rises on this edge
reset  in  1  synchronous, active-high reset
frame_end  in  1  one-cycle pulse between frames (screenEnd)
pix_valid  in  1  qualifies pix_x/pix_y this cycle
pix_x  in  X_W  downscaled pixel x
pix_y  in  Y_W  downscaled pixel y
sp_en_in  in  NUM_SPRITES  sprite enables, bit i = sprite i
sp_x_in  in  NUM_SPRITES*X_W  sprite left edges, sprite i at [i*X_W +: X_W]
sp_y_in  in  NUM_SPRITES*Y_W  sprite top edges
sp_base_in  in  NUM_SPRITES*SP_AW  GRAM base address per sprite (frame select)
sp_mem_addr  out  NUM_SPRITES*SP_AW  registered GRAM read addresses
sp_mem_data  in  NUM_SPRITES  GRAM read data, 1-cycle synchronous latency
bkg_data  in  1  background bit, aligned with sp_mem_data
out_valid  out  1  out_pix/out_src valid
out_pix  out  1  composited pixel bit
out_src  out  4  0 = background, i+1 = sprite i
coll_sp  out  NUM_SPRITES  sprite i overlapped another opaque sprite last frame
coll_bkg  out  NUM_SPRITES  sprite i opaque over background bit 1 last frame

Behaviour:
- Reset sets all registers to 0: shadow attributes, pipeline valids, sp_mem_addr, out_valid, out_pix, out_src, coll_sp, coll_bkg and the collision accumulators. After reset, sprites are disabled until the first frame_end.
- Shadow registers: on a cycle where frame_end=1, sp_en/x/y/base are captured from the *_in ports. All compositing uses the shadow values only. Changes to *_in mid-frame have no visible effect.
- Pipeline, with pixel presented in cycle t:
  - t+1: per-sprite hit register and sp_mem_addr register.
  - t+2: sp_mem_data and bkg_data are sampled.
  - t+3: out_valid, out_pix and out_src are valid.
  - Fixed latency of 3 cycles. One pixel per cycle throughput; no stalls.
- Hit: pix_x >= sx, pix_x < sx+SP_SIZE, pix_y >= sy, pix_y < sy+SP_SIZE, and en. Compare in X_W+1 / Y_W+1 bits so a sprite at x=250 covers 250..255 and never wraps to x=0..9.
- Address: base + (pix_x-sx) + (pix_y-sy)*SP_SIZE, truncated to SP_AW (modulo 2^SP_AW). When there is no hit, the address register holds its previous value.
- Opaque(i): hit_i and (TRANSPARENT==0 or sp_mem_data[i]==1).
- Priority: the lowest-index opaque sprite wins, and out_pix = its data. When TRANSPARENT==0, out_pix = its data bit, so 0 renders as color0. If no sprite is opaque: out_pix = bkg_data, out_src = 0.
- Collision accumulation, on valid stage-3 pixels only:
  - acc_sp[i] |= opaque(i) and any other opaque(j).
  - acc_bkg[i] |= opaque(i) and bkg_data.
- On frame_end: coll_* <= acc | the current-cycle contribution, and acc <= 0. A pixel in flight on the frame_end cycle therefore counts toward the closing frame. coll_* hold their value for the whole following frame.
- Bubbles: pix_valid=0 propagates as out_valid=0; out_pix/out_src hold their last value.
- frame_end and pix_valid asserted together are both honoured. The shadow update affects pixels entering from t+1 onward.
- Reset mid-frame flushes the pipeline. out_valid is 0 on the next cycle.

Test Plan:
- Reset, then frame_end with sprite0 en, x=10, y=20, base=0, sprite GRAM all 1. Pixel (10,20) -> sp_mem_addr[0]=0 at t+1; at t+3 out_valid=1, out_pix=1, out_src=1. Pixel (9,20) -> out_src=0.
- Address math: sprite1 x=4, y=4, base=0x40, SP_SIZE=16. Pixel (7,6) -> sp_mem_addr[1] = 0x40+3+32 = 0x63.
- Priority/transparency: sprites 0 and 2 at the same location, TRANSPARENT=1, sprite0 data 0 and sprite2 data 1 -> out_src=3, out_pix=1. With sprite0 data 1 -> out_src=1.
- Edge no-wrap: sprite x=250. Pixel x=3 -> out_src=0. Pixel x=255 -> out_src=1.
- Shadow update: change sp_x_in mid-frame -> output is unchanged until after the next frame_end pulse.
- Collision: sprites 0 and 1 overlap opaquely at one pixel, with bkg_data=1 there. After frame_end -> coll_sp=0b0011, coll_bkg=0b0011. Move them apart for the next frame -> coll_sp=0 after the following frame_end.
